// File: rtl/parity_sched.sv
// Round-robin scheduler sharing one nibble-parity XOR unit among four framed requesters.
// Optional completed-frame counter port frame_cnt enabled by PARITY_SCHED_STATS_EN.
module parity_sched #(
    parameter int unsigned CNT_W = 8
) (
    input  logic         clk1,
    input  logic         rst_n,
    input  logic [3:0]   req,
    input  logic [15:0]  nib,
    input  logic [3:0]   last,
    output logic [3:0]   gnt,
    output logic         res_valid,
    output logic [1:0]   res_id,
    output logic         res_par
`ifdef PARITY_SCHED_STATS_EN
    ,
    output logic [CNT_W-1:0] frame_cnt
`endif
);

    localparam int unsigned N     = 4;
    localparam int unsigned IDX_W = 2;
    localparam int unsigned NIB_W = 4;

    typedef enum logic {
        IDLE     = 1'b0,
        IN_FRAME = 1'b1
    } frame_state_t;

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [N-1:0]     acc_q, acc_d;
    frame_state_t     state_q [N];
    frame_state_t     state_d [N];

    logic [N-1:0]     grant_oh;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_any;
    logic [IDX_W-1:0] cand;
    logic [NIB_W-1:0] sel_nib;
    logic             nib_par;
    logic             grant_last;
    logic             frame_done;
    logic             frame_par;

    // Round-robin search starting at ptr_q; the first requesting index wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        grant_oh  = '0;
        for (int k = 0; k < N; k++) begin
            cand = ptr_q + IDX_W'(k);
            if (!grant_any && req[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
        if (grant_any) begin
            grant_oh = N'(1) << grant_idx;
        end
    end

    // Grant is forced off while reset is asserted.
    assign gnt = rst_n ? grant_oh : '0;

    // The single shared parity unit sees only the granted requester's nibble.
    assign sel_nib    = nib[grant_idx*NIB_W +: NIB_W];
    assign nib_par    = ^sel_nib;
    assign grant_last = last[grant_idx];
    assign frame_par  = acc_q[grant_idx] ^ nib_par;

    // Next-state logic for pointer, accumulators and per-requester frame FSMs.
    always_comb begin
        ptr_d      = ptr_q;
        acc_d      = acc_q;
        state_d    = state_q;
        frame_done = 1'b0;
        if (grant_any) begin
            ptr_d = grant_idx + IDX_W'(1);
            if (grant_last) begin
                acc_d[grant_idx]   = 1'b0;
                state_d[grant_idx] = IDLE;
                frame_done         = 1'b1;
            end else begin
                acc_d[grant_idx]   = frame_par;
                state_d[grant_idx] = IN_FRAME;
            end
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
            acc_q <= '0;
            for (int i = 0; i < N; i++) begin
                state_q[i] <= IDLE;
            end
        end else begin
            ptr_q   <= ptr_d;
            acc_q   <= acc_d;
            state_q <= state_d;
        end
    end

    // Result register: id/parity hold between completions.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_id    <= '0;
            res_par   <= 1'b0;
        end else begin
            res_valid <= frame_done;
            if (frame_done) begin
                res_id  <= grant_idx;
                res_par <= frame_par;
            end
        end
    end

`ifdef PARITY_SCHED_STATS_EN
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (frame_done) begin
            frame_cnt <= frame_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_parity_sched.sv
// Scoreboard bench for parity_sched: directed vectors push expected results, a monitor pops and compares.
module tb_parity_sched;

    localparam int unsigned CNT_W = 2;

    typedef struct packed {
        logic [1:0] id;
        logic       par;
    } exp_t;

    logic        clk1;
    logic        rst_n;
    logic [3:0]  req;
    logic [15:0] nib;
    logic [3:0]  last;
    logic [3:0]  gnt;
    logic        res_valid;
    logic [1:0]  res_id;
    logic        res_par;
`ifdef PARITY_SCHED_STATS_EN
    logic [CNT_W-1:0] frame_cnt;
`endif

    exp_t             q[$];
    logic [1:0]       m_id;
    logic             m_par;
    logic [CNT_W-1:0] m_cnt;
    int               n_checks;
    int               n_fail;

    parity_sched #(.CNT_W(CNT_W)) dut (
        .clk1      (clk1),
        .rst_n     (rst_n),
        .req       (req),
        .nib       (nib),
        .last      (last),
        .gnt       (gnt),
        .res_valid (res_valid),
        .res_id    (res_id),
        .res_par   (res_par)
`ifdef PARITY_SCHED_STATS_EN
        ,
        .frame_cnt (frame_cnt)
`endif
    );

    initial begin
        clk1 = 1'b0;
        forever #5 clk1 = ~clk1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops on every result pulse, otherwise checks that id/par/count hold.
    always @(negedge clk1) begin
        exp_t e;
        if (res_valid === 1'b1) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL spurious_res_valid: got res_valid=1 id=%0d, expected no result at %0t",
                         res_id, $time);
            end else begin
                e = q.pop_front();
                chk("res_id", 32'(res_id), 32'(e.id));
                chk("res_par", 32'(res_par), 32'(e.par));
                m_id  = e.id;
                m_par = e.par;
                m_cnt = m_cnt + CNT_W'(1);
`ifdef PARITY_SCHED_STATS_EN
                chk("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
`endif
            end
        end else begin
            chk("res_valid_low", 32'(res_valid), 32'd0);
            chk("res_id_hold", 32'(res_id), 32'(m_id));
            chk("res_par_hold", 32'(res_par), 32'(m_par));
`ifdef PARITY_SCHED_STATS_EN
            chk("frame_cnt_hold", 32'(frame_cnt), 32'(m_cnt));
`endif
        end
    end

    // Assert reset for one cycle with requests pending; gnt must stay 0000.
    task automatic do_reset();
        req   = 4'hF;
        nib   = 16'h0;
        last  = 4'h0;
        rst_n = 1'b0;
        m_id  = '0;
        m_par = 1'b0;
        m_cnt = '0;
        q.delete();
        @(negedge clk1);
        chk("gnt_in_reset", 32'(gnt), 32'd0);
        @(posedge clk1);
        #1;
        rst_n = 1'b1;
        req   = 4'h0;
    endtask

    // Present one vector, check the grant mid-cycle, queue the expected result, then take the edge.
    task automatic step(input string name, input logic [3:0] r, input logic [15:0] n,
                        input logic [3:0] l, input logic [3:0] eg,
                        input logic push, input logic [1:0] pid, input logic ppar);
        exp_t e;
        req  = r;
        nib  = n;
        last = l;
        @(negedge clk1);
        chk(name, 32'(gnt), 32'(eg));
        if (push) begin
            e.id  = pid;
            e.par = ppar;
            q.push_back(e);
        end
        @(posedge clk1);
        #1;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            step("gnt_idle", 4'h0, 16'h0, 4'h0, 4'h0, 1'b0, 2'd0, 1'b0);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        req      = 4'h0;
        nib      = 16'h0;
        last     = 4'h0;
        m_id     = '0;
        m_par    = 1'b0;
        m_cnt    = '0;
        n_checks = 0;
        n_fail   = 0;
        do_reset();
        idle(1);

        // Single-nibble frame: 1011 -> parity 1.
        step("gnt_single", 4'b0001, 16'h000B, 4'b0001, 4'b0001, 1'b1, 2'd0, 1'b1);
        idle(2);

        // Multi-nibble frame on requester 2: 0110, 0001, 1111 -> parity 1.
        step("gnt_multi0", 4'b0100, 16'h0600, 4'b0000, 4'b0100, 1'b0, 2'd0, 1'b0);
        step("gnt_multi1", 4'b0100, 16'h0100, 4'b0000, 4'b0100, 1'b0, 2'd0, 1'b0);
        step("gnt_multi2", 4'b0100, 16'h0F00, 4'b0100, 4'b0100, 1'b1, 2'd2, 1'b1);
        idle(2);

        // Round-robin with all requesting and no last: 0,1,2,3,0,1,2,3.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step("gnt_rr", 4'b1111, 16'h1111, 4'b0000, 4'(4'b0001 << (i % 4)),
                 1'b0, 2'd0, 1'b0);
        end
        idle(2);
        // Pointer held across idle cycles; requester 0 acc is 0 after two odd nibbles.
        step("gnt_rr_resume", 4'b1111, 16'h0001, 4'b0001, 4'b0001, 1'b1, 2'd0, 1'b1);
        idle(2);

        // Interleaved 2-nibble frames: R1 0011,0100 -> 1; R3 1000,1000 -> 0.
        do_reset();
        step("gnt_il0", 4'b1010, 16'h8030, 4'b0000, 4'b0010, 1'b0, 2'd0, 1'b0);
        step("gnt_il1", 4'b1010, 16'h8040, 4'b0010, 4'b1000, 1'b0, 2'd0, 1'b0);
        step("gnt_il2", 4'b1010, 16'h8040, 4'b1010, 4'b0010, 1'b1, 2'd1, 1'b1);
        step("gnt_il3", 4'b1000, 16'h8000, 4'b1000, 4'b1000, 1'b1, 2'd3, 1'b0);
        idle(2);

        // Reset mid-frame discards the partial 0001 nibble.
        do_reset();
        step("gnt_mid0", 4'b0001, 16'h0001, 4'b0000, 4'b0001, 1'b0, 2'd0, 1'b0);
        do_reset();
        step("gnt_mid1", 4'b0001, 16'h0000, 4'b0001, 4'b0001, 1'b1, 2'd0, 1'b0);
        idle(2);

        // Five single-nibble frames: counter wraps 1,2,3,0,1 at CNT_W=2.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step("gnt_cnt", 4'b0001, 16'h0001, 4'b0001, 4'b0001, 1'b1, 2'd0, 1'b1);
        end
        idle(3);

        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/parity_sched.md
PARITY_SCHED -- requirements
Module: parity_sched

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8, giving the width of the completed-frame counter (used only with PARITY_SCHED_STATS_EN).
REQ-002 The block SHALL have port clk1, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port req, input, 4 bits: req[i] high means requester i presents a nibble.
REQ-005 The block SHALL have port nib, input, 16 bits: requester i's nibble on nib[4i+3:4i].
REQ-006 The block SHALL have port last, input, 4 bits: last[i] marks requester i's current nibble as the final nibble of its frame.
REQ-007 The block SHALL have port gnt, output, 4 bits: one-hot grant, combinational from req and the priority pointer.
REQ-008 The block SHALL have port res_valid, output, 1 bit: registered one-cycle pulse marking a frame result.
REQ-009 The block SHALL have port res_id, output, 2 bits: registered index of the requester whose frame completed.
REQ-010 The block SHALL have port res_par, output, 1 bit: registered even parity (XOR of all bits) of the completed frame.
REQ-011 The block SHALL have port frame_cnt, output, CNT_W bits: completed-frame count; the port is present only with PARITY_SCHED_STATS_EN.

Function
REQ-012 The block SHALL share one 4-input XOR parity unit among four requesters, granting at most one requester per cycle.
REQ-013 Arbitration SHALL be round-robin: starting from pointer ptr (2 bits), gnt goes to the first i in order ptr, ptr+1, ptr+2, ptr+3 (mod 4) with req[i]=1.
REQ-014 When no req bit is set, gnt SHALL be 0000 and ptr, accumulators and frame states SHALL hold.
REQ-015 After a grant to requester i, ptr SHALL become (i+1) mod 4, wrapping 3 to 0.
REQ-016 Handshake: a requester SHALL hold req, nib and last stable until it samples gnt[i]=1 at a rising edge; that edge consumes the nibble.
REQ-017 Each requester SHALL have a 1-bit accumulator acc[i] and a 2-state frame FSM: IDLE (no nibble consumed) and IN_FRAME (one or more nibbles consumed, last not yet seen).
REQ-018 On a grant without last[i], acc[i] SHALL become acc[i] XOR (XOR of nib_i) and the FSM SHALL go to IN_FRAME.
REQ-019 On a grant with last[i], the edge SHALL set res_valid=1, res_id=i and res_par=acc[i] XOR (XOR of nib_i), clear acc[i] to 0 and return the FSM to IDLE; latency is 1 cycle from the grant edge.
REQ-020 A single-nibble frame (last high on the first grant from IDLE) SHALL produce res_par = XOR of that nibble.
REQ-021 In any cycle without a last-grant, res_valid SHALL be 0, and res_id and res_par SHALL hold their previous values.
REQ-022 Non-granted requesters SHALL keep acc and FSM state unchanged, including when several requests are pending at once.

Reset
REQ-023 When rst_n is low, the block SHALL immediately clear ptr, all acc[i], res_valid, res_id, res_par and frame_cnt to 0, and set all FSMs to IDLE.
REQ-024 While rst_n is low, gnt SHALL be 0000.
REQ-025 A reset mid-frame SHALL discard the partial frame with no result pulse.

Configuration
REQ-026 When macro PARITY_SCHED_STATS_EN is defined, the block SHALL include frame_cnt, incremented by 1 on every res_valid-producing edge and wrapping from 2^CNT_W-1 to 0.
REQ-027 When PARITY_SCHED_STATS_EN is undefined, the block SHALL have no frame_cnt port or counter logic, and all other behaviour SHALL be identical.

Verification
REQ-028 The bench SHALL cover a single frame: reset, then req=0001, nib[3:0]=1011, last=0001 for one edge -> gnt=0001, next cycle res_valid=1, res_id=0, res_par=1.
REQ-029 The bench SHALL cover a multi-nibble frame: requester 2 sends 0110, then 0001, then 1111 (last on the third) -> exactly one res_valid, res_id=2, res_par=1.
REQ-030 The bench SHALL cover round-robin order: req=1111 held with last=0000 for 8 edges -> grant order 0,1,2,3,0,1,2,3, and no res_valid.
REQ-031 The bench SHALL cover interleaving: requesters 1 and 3 both active, each sending 2-nibble frames (R1: 0011, 0100; R3: 1000, 1000) -> R1 result res_par=1, R3 result res_par=0, with no cross-contamination.
REQ-032 The bench SHALL cover reset mid-frame: requester 0 consumes 0001, rst_n is pulsed low, then requester 0 sends 0000 with last -> res_par=0.
REQ-033 The bench SHALL cover the counter (PARITY_SCHED_STATS_EN, CNT_W=2): 5 completed frames -> frame_cnt sequence 1,2,3,0,1.
